tm_display_serializer: RTL and testbench

Downstream output stage for the Turing machine core. It snapshots the core's 11-bit tape display window, 4-bit FSM state code and compute-done flag into one frame. It shifts that frame off-chip over a three-wire serial link (clock, data, latch) so an external shift-register/LED board can show it. This keeps the full status readable through the few spare output pins.

---
 rtl/tm_ser_pkg.sv | 34 +++
 rtl/tm_ser_bitclk.sv | 56 +++++
 rtl/tm_display_serializer.sv | 162 ++++++++++++++++
 tb/tb_tm_display_serializer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tm_ser_pkg.sv
// ============================================================================
//  Module      : tm_ser_pkg
//  Description : Shared types and frame-width helper for the Turing machine
//                display serializer.
//                Optional feature macro: TM_SER_PARITY_EN (even-parity bit
//                appended after the display LSB).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package tm_ser_pkg;

  // Serializer FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } ser_state_t;

  // Width of the parity term appended to the frame
`ifdef TM_SER_PARITY_EN
  localparam int PARITY_W = 1;
`else
  localparam int PARITY_W = 0;
`endif

  // Frame = {done, state, display} plus the optional parity bit
  function automatic int frame_width(input int disp_w, input int state_w);
    return 1 + state_w + disp_w + PARITY_W;
  endfunction

endpackage : tm_ser_pkg

`default_nettype wire

// File: rtl/tm_ser_bitclk.sv
// ============================================================================
//  Module      : tm_ser_bitclk
//  Description : Bit-period phase counter for the display serializer. Counts
//                0..2*DIV-1 while enabled, drives a registered serial clock
//                (low for the first DIV cycles, high for the second DIV) and
//                flags the last cycle of each bit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tm_ser_bitclk #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_sclk,
  output logic o_tick
);

  // 2*255-1 = 509 fits in 9 bits
  localparam int                PH_W   = 9;
  localparam logic [PH_W-1:0]   c_last = PH_W'(2 * DIV - 1);
  localparam logic [PH_W-1:0]   c_half = PH_W'(DIV);

  logic [PH_W-1:0] r_phase;
  logic            r_sclk;
  logic [PH_W-1:0] w_phase_inc;

  assign w_phase_inc = r_phase + 1'b1;
  assign o_tick      = i_enable & (r_phase == c_last);
  assign o_sclk      = r_sclk;

  // Phase counter; sclk is registered alongside so it always equals (phase >= DIV)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
      r_sclk  <= 1'b0;
    end else if (i_clear) begin
      r_phase <= '0;
      r_sclk  <= 1'b0;
    end else if (i_enable) begin
      if (r_phase == c_last) begin
        r_phase <= '0;
        r_sclk  <= 1'b0;
      end else begin
        r_phase <= w_phase_inc;
        r_sclk  <= (w_phase_inc >= c_half);
      end
    end
  end

endmodule : tm_ser_bitclk

`default_nettype wire

// File: rtl/tm_display_serializer.sv
// ============================================================================
//  Module      : tm_display_serializer
//  Description : Snapshots {done, state, display} from the Turing machine core
//                and shifts it MSB first over a clock/data/latch serial link
//                to an external shift-register board. A frame is sent after
//                reset, whenever the snapshot changes, or on a force request.
//                Optional feature macro: TM_SER_PARITY_EN (even-parity bit
//                appended after the display LSB).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tm_display_serializer
  import tm_ser_pkg::*;
#(
  parameter int DISP_W  = 11,
  parameter int STATE_W = 4,
  parameter int DIV     = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DISP_W-1:0]  i_display,
  input  logic [STATE_W-1:0] i_state,
  input  logic               i_done,
  input  logic               i_force,
  output logic               o_sclk,
  output logic               o_sdata,
  output logic               o_slatch,
  output logic               o_busy
);

  localparam int BASE_W  = 1 + STATE_W + DISP_W;
  localparam int FRAME_W = frame_width(DISP_W, STATE_W);
  localparam int CNT_W   = $clog2(FRAME_W);

  localparam logic [1:0]       ST_IDLE    = IDLE;
  localparam logic [1:0]       ST_SHIFT   = SHIFT;
  localparam logic [1:0]       ST_LATCH   = LATCH;
  localparam logic [CNT_W-1:0] c_bit_top  = CNT_W'(FRAME_W - 1);
  localparam logic [7:0]       c_lat_last = 8'(DIV - 1);

  logic [1:0]         r_state;
  logic [FRAME_W-1:0] r_shreg;
  logic [FRAME_W-1:0] r_last_sent;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [7:0]         r_lat_cnt;
  logic               r_force_pend;
  logic               r_first;
  logic               r_sdata;
  logic               r_slatch;
  logic               r_busy;

  logic [BASE_W-1:0]  w_frame_base;
  logic [FRAME_W-1:0] w_frame_now;
  logic               w_send;
  logic               w_bit_en;
  logic               w_bit_clr;
  logic               w_tick;
  logic               w_sclk;

  assign w_frame_base = {i_done, i_state, i_display};

`ifdef TM_SER_PARITY_EN
  // Even parity over the captured snapshot, placed after the display LSB
  assign w_frame_now = {w_frame_base, ^w_frame_base};
`else
  assign w_frame_now = w_frame_base;
`endif

  assign w_send    = (w_frame_now != r_last_sent) | i_force | r_force_pend | r_first;
  assign w_bit_en  = (r_state == ST_SHIFT);
  assign w_bit_clr = (r_state != ST_SHIFT);

  tm_ser_bitclk #(
    .DIV      (DIV)
  ) u_bitclk (
    .clock    (clock),
    .reset    (reset),
    .i_enable (w_bit_en),
    .i_clear  (w_bit_clr),
    .o_sclk   (w_sclk),
    .o_tick   (w_tick)
  );

  assign o_sclk   = w_sclk;
  assign o_sdata  = r_sdata;
  assign o_slatch = r_slatch;
  assign o_busy   = r_busy;

  // Frame FSM: load snapshot, shift bits out on each end-of-bit tick, then latch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_last_sent  <= '0;
      r_bit_cnt    <= '0;
      r_lat_cnt    <= '0;
      r_force_pend <= 1'b0;
      r_first      <= 1'b1;
      r_sdata      <= 1'b0;
      r_slatch     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_send) begin
            r_shreg      <= w_frame_now;
            r_last_sent  <= w_frame_now;
            r_bit_cnt    <= c_bit_top;
            r_first      <= 1'b0;
            r_force_pend <= 1'b0;
            r_sdata      <= w_frame_now[FRAME_W-1];
            r_busy       <= 1'b1;
            r_state      <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // A force during a frame is held until the link is idle again
          if (i_force) begin
            r_force_pend <= 1'b1;
          end
          if (w_tick) begin
            r_shreg <= r_shreg << 1;
            if (r_bit_cnt == '0) begin
              r_sdata   <= 1'b0;
              r_slatch  <= 1'b1;
              r_lat_cnt <= '0;
              r_state   <= ST_LATCH;
            end else begin
              r_bit_cnt <= r_bit_cnt - 1'b1;
              r_sdata   <= r_shreg[FRAME_W-2];
            end
          end
        end

        ST_LATCH: begin
          if (i_force) begin
            r_force_pend <= 1'b1;
          end
          if (r_lat_cnt == c_lat_last) begin
            r_slatch <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end

        default: begin
          r_sdata  <= 1'b0;
          r_slatch <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : tm_display_serializer

`default_nettype wire

// File: tb/tb_tm_display_serializer.sv
// ============================================================================
//  Module      : tb_tm_display_serializer
//  Description : Directed self-checking bench for tm_display_serializer.
//                Honours TM_SER_PARITY_EN for the expected frame width/content.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tm_display_serializer;

  localparam int TB_DIV = 4;
`ifdef TM_SER_PARITY_EN
  localparam int TB_FW = 17;
`else
  localparam int TB_FW = 16;
`endif
  localparam int TB_FRAME_CYC = TB_FW * 2 * TB_DIV + TB_DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] r_display = 11'h555;
  logic [3:0]  r_state_in = 4'h3;
  logic        r_done = 1'b0;
  logic        r_force = 1'b0;
  logic        w_sclk, w_sdata, w_slatch, w_busy;

  int n_checks = 0;
  int n_errors = 0;

  tm_display_serializer #(
    .DISP_W    (11),
    .STATE_W   (4),
    .DIV       (TB_DIV)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .i_display (r_display),
    .i_state   (r_state_in),
    .i_done    (r_done),
    .i_force   (r_force),
    .o_sclk    (w_sclk),
    .o_sdata   (w_sdata),
    .o_slatch  (w_slatch),
    .o_busy    (w_busy)
  );

  always #5 clock = ~clock;

  // Link monitor: emulates the external board, sampling sdata on sclk rises
  logic        prev_sclk = 1'b0;
  logic        prev_busy = 1'b0;
  int          frames = 0;
  int          sclk_rises = 0;
  int          nbits = 0;
  int          busy_cycles = 0;
  int          latch_cycles = 0;
  logic [31:0] cap = '0;

  always @(negedge clock) begin
    if (w_busy && !prev_busy) begin
      frames++;
      busy_cycles  = 0;
      latch_cycles = 0;
      nbits        = 0;
      cap          = '0;
    end
    if (w_busy)   busy_cycles++;
    if (w_slatch) latch_cycles++;
    if (w_sclk && !prev_sclk) begin
      sclk_rises++;
      nbits++;
      cap = {cap[30:0], w_sdata};
    end
    prev_sclk = w_sclk;
    prev_busy = w_busy;
  end

  function automatic logic [31:0] exp_frame(input logic d, input logic [3:0] s, input logic [10:0] x);
    logic [15:0] b;
    b = {d, s, x};
`ifdef TM_SER_PARITY_EN
    return {15'b0, b, ^b};
`else
    return {16'b0, b};
`endif
  endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge (monitor has already sampled)
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (w_busy && n < 400) begin
      tick();
      n++;
    end
    check_value(tag, {31'b0, w_busy}, 32'd0);
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (!w_busy && n < 4) begin
      tick();
      n++;
    end
    check_value(tag, {31'b0, w_busy}, 32'd1);
  endtask

  task automatic pulse_force();
    r_force = 1'b1;
    tick();
    r_force = 1'b0;
  endtask

  int f0;
  int s0;

  initial begin
    // ---- reset state ----
    ticks(3);
    check_value("rst_sclk",   {31'b0, w_sclk},   32'd0);
    check_value("rst_sdata",  {31'b0, w_sdata},  32'd0);
    check_value("rst_slatch", {31'b0, w_slatch}, 32'd0);
    check_value("rst_busy",   {31'b0, w_busy},   32'd0);

    // ---- first frame after reset ----
    reset = 1'b0;
    tick();
    check_value("first_busy_lat", {31'b0, w_busy}, 32'd1);
    check_value("first_msb", {31'b0, w_sdata}, {31'b0, exp_frame(1'b0, 4'h3, 11'h555)[TB_FW-1]});
    wait_idle("first_end");
    check_value("first_frame",  cap, exp_frame(1'b0, 4'h3, 11'h555));
    check_value("first_nbits",  nbits, TB_FW);
    check_value("first_latch",  latch_cycles, TB_DIV);
    check_value("first_dur",    busy_cycles, TB_FRAME_CYC);
    check_value("first_frames", frames, 1);

    // ---- quiet when inputs held ----
    f0 = frames;
    s0 = sclk_rises;
    ticks(1000);
    check_value("quiet_frames", frames - f0, 0);
    check_value("quiet_sclk",   sclk_rises - s0, 0);

    // ---- input changes mid-frame: current completes, latest sent once ----
    f0 = frames;
    pulse_force();
    check_value("mid_busy", {31'b0, w_busy}, 32'd1);
    ticks(40);
    r_display = 11'h001;
    ticks(40);
    r_display = 11'h002;
    wait_idle("mid_end1");
    check_value("mid_cur", cap, exp_frame(1'b0, 4'h3, 11'h555));
    wait_busy("mid_gap");
    wait_idle("mid_end2");
    check_value("mid_new", cap, exp_frame(1'b0, 4'h3, 11'h002));
    ticks(200);
    check_value("mid_frames", frames - f0, 2);

    // ---- three forces during a frame collapse to one resend ----
    f0 = frames;
    r_display = 11'h7FF;
    tick();
    ticks(10);
    pulse_force();
    ticks(40);
    pulse_force();
    ticks(40);
    pulse_force();
    wait_idle("frc_end1");
    check_value("frc_frame1", cap, exp_frame(1'b0, 4'h3, 11'h7FF));
    wait_busy("frc_gap");
    wait_idle("frc_end2");
    check_value("frc_frame2", cap, exp_frame(1'b0, 4'h3, 11'h7FF));
    ticks(300);
    check_value("frc_frames", frames - f0, 2);

    // ---- simultaneous force and data change give one frame ----
    f0 = frames;
    r_done = 1'b1;
    r_state_in = 4'hA;
    r_display = 11'h001;
    r_force = 1'b1;
    tick();
    r_force = 1'b0;
    wait_idle("sim_end");
    check_value("sim_frame", cap, exp_frame(1'b1, 4'hA, 11'h001));
    ticks(200);
    check_value("sim_frames", frames - f0, 1);

    // ---- reset mid-frame at bit 7 ----
    r_done = 1'b0;
    r_state_in = 4'h3;
    r_display = 11'h0F0;
    wait_busy("mrst_start");
    for (int n = 0; n < 200 && nbits < 7; n++) tick();
    check_value("mrst_bit7", nbits, 7);
    reset = 1'b1;
    #1;
    check_value("mrst_sclk",   {31'b0, w_sclk},   32'd0);
    check_value("mrst_sdata",  {31'b0, w_sdata},  32'd0);
    check_value("mrst_slatch", {31'b0, w_slatch}, 32'd0);
    check_value("mrst_busy",   {31'b0, w_busy},   32'd0);
    ticks(3);
    reset = 1'b0;
    wait_busy("mrst_restart");
    wait_idle("mrst_end");
    check_value("mrst_frame", cap, exp_frame(1'b0, 4'h3, 11'h0F0));
    check_value("mrst_nbits", nbits, TB_FW);
    check_value("mrst_dur",   busy_cycles, TB_FRAME_CYC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_tm_display_serializer

`default_nettype wire
